// File: rtl/rf_hilo_if.sv
// rf_hilo_if: write-back bus, GPR read addresses and read data of the register file.
interface rf_hilo_if;
  logic [103:0] wb_to_rf_bus;
  logic [4:0]   raddr1;
  logic [4:0]   raddr2;
  logic [31:0]  rdata1;
  logic [31:0]  rdata2;
  logic [31:0]  hi_rdata;
  logic [31:0]  lo_rdata;
  modport master (
    output wb_to_rf_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_rdata, lo_rdata
  );
  modport slave (
    input  wb_to_rf_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/rf_hilo.sv
// rf_hilo: 32x32 GPR file plus HI/LO registers with optional same-cycle write-to-read forwarding.
module rf_hilo #(
  parameter bit BYPASS_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  rf_hilo_if.slave  bus
);
  logic [31:0] r_gpr [32];
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_hi_we;
  logic        w_lo_we;
  logic        w_rf_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_rf_wdata;
  logic [31:0] w_hi_wdata;
  logic [31:0] w_lo_wdata;
  logic        w_byp;
  assign {w_hi_we, w_lo_we, w_rf_we, w_waddr, w_rf_wdata, w_hi_wdata, w_lo_wdata} = bus.wb_to_rf_bus;
  // forwarding is suppressed during reset so outputs show the cleared state
  assign w_byp = BYPASS_EN && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_rf_we && w_waddr != 5'd0) r_gpr[w_waddr] <= w_rf_wdata;
      if (w_hi_we) r_hi <= w_hi_wdata;
      if (w_lo_we) r_lo <= w_lo_wdata;
    end
  end
  assign bus.rdata1   = (bus.raddr1 == 5'd0) ? '0 :
                        (w_byp && w_rf_we && w_waddr == bus.raddr1) ? w_rf_wdata : r_gpr[bus.raddr1];
  assign bus.rdata2   = (bus.raddr2 == 5'd0) ? '0 :
                        (w_byp && w_rf_we && w_waddr == bus.raddr2) ? w_rf_wdata : r_gpr[bus.raddr2];
  assign bus.hi_rdata = (w_byp && w_hi_we) ? w_hi_wdata : r_hi;
  assign bus.lo_rdata = (w_byp && w_lo_we) ? w_lo_wdata : r_lo;
endmodule
